// File: rtl/risc_pkg.sv
// Shared constants and encodings for the RISC data-memory path.
// Widths, FSM state encoding and read/write strobe polarity.
package risc_pkg;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_ACCESS = 2'd1,
    DM_DONE   = 2'd2
  } dm_state_t;

  localparam logic DM_RD = 1'b1;
  localparam logic DM_WR = 1'b0;

endpackage

// File: rtl/risc_dmem_array.sv
// 2**AW x DW storage: async clear, one synchronous write port, one combinational read port.
// No control logic; the caller decides when to write and when to sample the read data.
module risc_dmem_array #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_dmem.sv
// Data-memory responder: captures a request, waits WAIT_CYC cycles, commits, then pulses dm_rdy.
// Latency WAIT_CYC+1 edges from capture to commit; requests arriving while busy are dropped.
module risc_dmem
  import risc_pkg::*;
#(
  parameter int DW       = risc_pkg::DW,
  parameter int AW       = risc_pkg::AW,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dmenbl,
  input  logic          rdwr,
  input  logic [AW-1:0] dmaddr,
  input  logic [DW-1:0] dmdatain,
  output logic [DW-1:0] dmdataout,
  output logic          dm_rdy,
  output logic          dm_busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  dm_state_t     state, state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          cap_rdwr;
  logic          capture;
  logic          commit;
  logic          we;
  logic [DW-1:0] rdata;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      DM_IDLE: begin
        if (dmenbl) begin
          capture   = 1'b1;
          state_nxt = DM_ACCESS;
        end
      end
      DM_ACCESS: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = DM_DONE;
        end
      end
      DM_DONE: begin
        // A request held through DONE is taken immediately (back-to-back).
        if (dmenbl) begin
          capture   = 1'b1;
          state_nxt = DM_ACCESS;
        end else begin
          state_nxt = DM_IDLE;
        end
      end
      default: state_nxt = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DM_IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_rdwr  <= 1'b0;
      dmdataout <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_addr <= dmaddr;
        cap_data <= dmdatain;
        cap_rdwr <= rdwr;
        cnt      <= WAIT_INIT;
      end else if (state == DM_ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && cap_rdwr == DM_RD) dmdataout <= rdata;
    end
  end

  assign we      = commit && (cap_rdwr == DM_WR);
  assign dm_rdy  = (state == DM_DONE);
  assign dm_busy = (state == DM_ACCESS);

  risc_dmem_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (cap_addr),
    .wdata (cap_data),
    .raddr (cap_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_risc_dmem.sv
// Directed bench for risc_dmem: unit 0 runs WAIT_CYC=1, unit 1 runs WAIT_CYC=0.
// Expected dmdataout per completion is queued at request time and popped on dm_rdy.
module tb_risc_dmem;

  logic       clk;
  logic       rst_n;
  logic       en   [2];
  logic       rw   [2];
  logic [3:0] ad   [2];
  logic [7:0] di   [2];
  logic [7:0] dout [2];
  logic       rdy  [2];
  logic       busy [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m   [2][16];
  logic [7:0] last_rd [2];
  logic [7:0] sb [$];

  risc_dmem #(.DW(8), .AW(4), .WAIT_CYC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dmenbl(en[0]), .rdwr(rw[0]), .dmaddr(ad[0]),
    .dmdatain(di[0]), .dmdataout(dout[0]), .dm_rdy(rdy[0]), .dm_busy(busy[0])
  );

  risc_dmem #(.DW(8), .AW(4), .WAIT_CYC(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dmenbl(en[1]), .rdwr(rw[1]), .dmaddr(ad[1]),
    .dmdatain(di[1]), .dmdataout(dout[1]), .dm_rdy(rdy[1]), .dm_busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      last_rd[u] = 8'h00;
      for (int i = 0; i < 16; i++) mem_m[u][i] = 8'h00;
    end
    sb.delete();
  endtask

  // Issue one request; optionally keep dmenbl high as a write of 3Ch during ACCESS.
  task automatic req(input int u, input logic rd, input logic [3:0] a, input logic [7:0] d,
                     input bit intrude, input string tag);
    int c;
    int busy_n;
    logic [7:0] e;
    @(negedge clk);
    en[u] = 1'b1; rw[u] = rd; ad[u] = a; di[u] = d;
    sb.push_back(rd ? mem_m[u][a] : last_rd[u]);
    if (rd) last_rd[u] = mem_m[u][a];
    else    mem_m[u][a] = d;
    @(negedge clk);
    if (intrude) begin
      rw[u] = 1'b0; di[u] = 8'h3C;
    end else begin
      en[u] = 1'b0;
    end
    c = 0; busy_n = 0;
    while (!rdy[u] && c < 20) begin
      if (busy[u]) busy_n++;
      @(negedge clk);
      c++;
      en[u] = 1'b0;
    end
    chk({tag, "_rdy_seen"}, 32'(rdy[u]), 32'd1);
    chk({tag, "_latency"}, 32'(c), (u == 0) ? 32'd2 : 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), (u == 0) ? 32'd2 : 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    chk({tag, "_dout"}, 32'(dout[u]), 32'(e));
    @(negedge clk);
    chk({tag, "_single_pulse"}, {30'd0, rdy[u], busy[u]}, 32'd0);
  endtask

  initial begin
    int c;
    logic [7:0] e;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      en[u] = 1'b0; rw[u] = 1'b0; ad[u] = 4'h0; di[u] = 8'h00;
    end
    model_reset();
    #12;
    for (int u = 0; u < 2; u++) begin
      chk("reset_dout", 32'(dout[u]), 32'h0);
      chk("reset_rdy",  32'(rdy[u]),  32'h0);
      chk("reset_busy", 32'(busy[u]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    req(0, 1'b1, 4'h5, 8'h00, 1'b0, "rd5");
    req(0, 1'b0, 4'h3, 8'hA5, 1'b0, "wr3");
    req(0, 1'b1, 4'h3, 8'h00, 1'b0, "rd3");
    req(0, 1'b0, 4'h0, 8'h11, 1'b0, "wr0");
    req(0, 1'b0, 4'hF, 8'hEE, 1'b0, "wrF");
    req(0, 1'b1, 4'hF, 8'h00, 1'b0, "rdF");
    req(0, 1'b1, 4'h0, 8'h00, 1'b0, "rd0");
    req(0, 1'b1, 4'hF, 8'h00, 1'b1, "rdF_drop");
    req(0, 1'b1, 4'hF, 8'h00, 1'b0, "rdF_after");

    // Back-to-back: read 0 held through DONE.
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 4'h0;
    sb.push_back(mem_m[0][0]);
    sb.push_back(mem_m[0][0]);
    c = 0;
    @(negedge clk);
    while (!rdy[0] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_first_latency", 32'(c), 32'd2);
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    chk("b2b_first_dout", 32'(dout[0]), 32'(e));
    c = 0;
    @(negedge clk);
    c++;
    en[0] = 1'b0;
    chk("b2b_recapture_busy", 32'(busy[0]), 32'd1);
    while (!rdy[0] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_gap", 32'(c), 32'd3);
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    chk("b2b_second_dout", 32'(dout[0]), 32'(e));
    @(negedge clk);
    chk("b2b_idle", {30'd0, rdy[0], busy[0]}, 32'd0);

    req(1, 1'b0, 4'h2, 8'h5A, 1'b0, "w0_wr2");
    req(1, 1'b1, 4'h2, 8'h00, 1'b0, "w0_rd2");

    // Reset in the middle of a write on unit 0.
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b0; ad[0] = 4'h7; di[0] = 8'hFF;
    @(negedge clk);
    en[0] = 1'b0;
    chk("midrst_busy_before", 32'(busy[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout[0]), 32'h0);
    chk("midrst_busy", 32'(busy[0]), 32'h0);
    chk("midrst_rdy",  32'(rdy[0]),  32'h0);
    chk("midrst_w0_dout", 32'(dout[1]), 32'h0);
    model_reset();
    @(negedge clk);
    chk("midrst_no_rdy", 32'(rdy[0]), 32'h0);
    rst_n = 1'b1;
    req(0, 1'b1, 4'h7, 8'h00, 1'b0, "rd7_after_rst");
    req(1, 1'b1, 4'h2, 8'h00, 1'b0, "w0_rd2_after_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
